sr_latch_bank: RTL and testbench

Parametrised, clocked bank of SR latches. Replaces the single free-running cross-coupled NAND latch with CHANNELS independent synchronous channels. Each channel runs its active-low set/reset pins through a synchroniser and a glitch filter, and resolves simultaneous set+reset according to a run-time mode. It sits between raw user input pins and the project logic, giving clean latched levels plus change/conflict pulses.

---
 rtl/sr_latch_pkg.sv | 25 ++
 rtl/sr_latch_bank_channel.sv | 137 +++++++++++++
 rtl/sr_latch_bank.sv | 41 ++++
 tb/tb_sr_latch_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared constants for the SR latch bank: conflict-policy encodings and
// counter sizing helpers used by every channel.
`timescale 1ns/1ps
package sr_latch_pkg;

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_SET_DOM = 2'b01;
  localparam logic [1:0] MODE_RST_DOM = 2'b10;
  localparam logic [1:0] MODE_TOGGLE  = 2'b11;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Filter counter width; never zero so declarations stay legal when bypassed.
  function automatic int cnt_width(input int filter_cycles);
    int w;
    w = clog2(filter_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sr_latch_bank_channel.sv
// One latch channel: two input synchronisers, two glitch filters, the latch
// with its conflict policy, and registered change/conflict pulses.
`timescale 1ns/1ps
module sr_latch_channel
  import sr_latch_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       s_n,
  input  logic       r_n,
  input  logic [1:0] mode,
  output logic       q,
  output logic       qn,
  output logic       changed,
  output logic       conflict
);

  localparam int CNT_W = cnt_width(FILTER_CYCLES);

  // Index 0 carries the set path, index 1 the reset path.
  logic [1:0]                  in_n;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0][SYNC_STAGES-1:0] sync_d;
  logic [1:0]                  sync_out;
  logic [1:0]                  filt;

  assign in_n = {r_n, s_n};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], in_n[i]};
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign filt = sync_out;
    end else begin : g_filter
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

      logic [1:0][CNT_W-1:0] cnt_q;
      logic [1:0][CNT_W-1:0] cnt_d;
      logic [1:0]            filt_q;
      logic [1:0]            filt_d;

      // The filtered level only moves after FILTER_CYCLES consecutive mismatches.
      always_comb begin
        for (int i = 0; i < 2; i++) begin
          cnt_d[i]  = '0;
          filt_d[i] = filt_q[i];
          if (sync_out[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_LAST) filt_d[i] = sync_out[i];
            else                      cnt_d[i]  = cnt_q[i] + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q  <= '0;
          filt_q <= '1;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  logic set_req;
  logic rst_req;
  logic both;
  logic q_q, q_d;
  logic changed_q, changed_d;
  logic conflict_q, conflict_d;
  logic armed_q, armed_d;

  assign set_req = ~filt[0];
  assign rst_req = ~filt[1];
  assign both    = set_req & rst_req;

  // armed_q records that both requests were active last cycle, so a conflict
  // already in progress neither re-pulses nor re-toggles.
  always_comb begin
    q_d = q_q;
    if (ena) begin
      unique case ({set_req, rst_req})
        2'b10: q_d = 1'b1;
        2'b01: q_d = 1'b0;
        2'b11: begin
          unique case (mode)
            MODE_SET_DOM: q_d = 1'b1;
            MODE_RST_DOM: q_d = 1'b0;
            MODE_TOGGLE:  if (!armed_q) q_d = ~q_q;
            default:      q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
    changed_d  = (q_d != q_q);
    conflict_d = both & ~armed_q;
    armed_d    = both;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= 1'b0;
      changed_q  <= 1'b0;
      conflict_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      q_q        <= q_d;
      changed_q  <= changed_d;
      conflict_q <= conflict_d;
      armed_q    <= armed_d;
    end
  end

  assign q        = q_q;
  assign qn       = ~q_q;
  assign changed  = changed_q;
  assign conflict = conflict_q;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of independent clocked SR latch channels sharing clock, reset,
// enable and conflict mode.
`timescale 1ns/1ps
module sr_latch_bank
  import sr_latch_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [CHANNELS-1:0] s_n,
  input  logic [CHANNELS-1:0] r_n,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] qn,
  output logic [CHANNELS-1:0] changed,
  output logic [CHANNELS-1:0] conflict
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sr_latch_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .s_n     (s_n[i]),
      .r_n     (r_n[i]),
      .mode    (mode),
      .q       (q[i]),
      .qn      (qn[i]),
      .changed (changed[i]),
      .conflict(conflict[i])
    );
  end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench for sr_latch_bank with default parameters (8 channels,
// 2 sync stages, 4-cycle filter => 7-edge latency from pin to q).
`timescale 1ns/1ps
module tb_sr_latch_bank;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] s_n;
  logic [7:0] r_n;
  logic [1:0] mode;
  logic [7:0] q;
  logic [7:0] qn;
  logic [7:0] changed;
  logic [7:0] conflict;

  int checks;
  int errors;

  sr_latch_bank #(
    .CHANNELS     (8),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .s_n     (s_n),
    .r_n     (r_n),
    .mode    (mode),
    .q       (q),
    .qn      (qn),
    .changed (changed),
    .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_n   = '1;
    r_n   = '1;
    ena   = 1'b1;
    mode  = 2'b00;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_n   = '1;
    r_n   = '1;
    ena   = 1'b1;
    mode  = 2'b00;
    step(3);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
    checks++; if (qn !== 8'hFF) begin errors++; $display("FAIL reset_qn: got %h expected %h", qn, 8'hFF); end
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL reset_changed: got %h expected %h", changed, 8'h00); end
    checks++; if (conflict !== 8'h00) begin errors++; $display("FAIL reset_conflict: got %h expected %h", conflict, 8'h00); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_set_latency();
    s_n[3] = 1'b0;
    step(6);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL set_early_q: got %h expected %h", q, 8'h00); end
    step(1);
    checks++; if (q !== 8'h08) begin errors++; $display("FAIL set_edge7_q: got %h expected %h", q, 8'h08); end
    checks++; if (changed !== 8'h08) begin errors++; $display("FAIL set_edge7_changed: got %h expected %h", changed, 8'h08); end
    checks++; if (qn !== 8'hF7) begin errors++; $display("FAIL set_edge7_qn: got %h expected %h", qn, 8'hF7); end
    step(1);
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL set_pulse_end: got %h expected %h", changed, 8'h00); end
    checks++; if (q !== 8'h08) begin errors++; $display("FAIL set_hold_q: got %h expected %h", q, 8'h08); end
  endtask

  task automatic test_glitch();
    int seen;
    do_reset();
    s_n[0] = 1'b0;
    step(8);
    s_n[0] = 1'b1;
    step(8);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL glitch_pre_q: got %h expected %h", q, 8'h01); end
    seen = 0;
    r_n[0] = 1'b0;
    step(3);
    r_n[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (changed !== 8'h00) seen++;
    end
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL glitch3_q: got %h expected %h", q, 8'h01); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL glitch3_changed: got %0d pulses expected 0", seen); end
    r_n[0] = 1'b0;
    step(4);
    r_n[0] = 1'b1;
    step(2);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL glitch4_early_q: got %h expected %h", q, 8'h01); end
    step(1);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL glitch4_q: got %h expected %h", q, 8'h00); end
    checks++; if (changed !== 8'h01) begin errors++; $display("FAIL glitch4_changed: got %h expected %h", changed, 8'h01); end
  endtask

  task automatic test_conflict_modes();
    int conf_cnt;
    int chg_cnt;
    logic exp_q;
    for (int m = 0; m < 4; m++) begin
      for (int qv = 0; qv < 2; qv++) begin
        do_reset();
        if (qv == 1) begin
          s_n[5] = 1'b0;
          step(8);
          s_n[5] = 1'b1;
          step(8);
        end
        checks++; if (q[5] !== qv[0]) begin errors++; $display("FAIL conflict_pre m=%0d: got %b expected %b", m, q[5], qv[0]); end
        mode = m[1:0];
        case (m)
          0: exp_q = qv[0];
          1: exp_q = 1'b1;
          2: exp_q = 1'b0;
          default: exp_q = ~qv[0];
        endcase
        conf_cnt = 0;
        chg_cnt  = 0;
        s_n[5] = 1'b0;
        r_n[5] = 1'b0;
        for (int k = 0; k < 14; k++) begin
          step(1);
          if (conflict[5] === 1'b1) conf_cnt++;
          if (changed[5] === 1'b1) chg_cnt++;
        end
        checks++; if (q[5] !== exp_q) begin errors++; $display("FAIL conflict_q m=%0d q0=%0d: got %b expected %b", m, qv, q[5], exp_q); end
        checks++; if (conf_cnt !== 1) begin errors++; $display("FAIL conflict_pulses m=%0d q0=%0d: got %0d expected 1", m, qv, conf_cnt); end
        checks++; if (chg_cnt !== ((exp_q != qv[0]) ? 1 : 0)) begin errors++; $display("FAIL conflict_changed m=%0d q0=%0d: got %0d expected %0d", m, qv, chg_cnt, (exp_q != qv[0]) ? 1 : 0); end
        s_n[5] = 1'b1;
        r_n[5] = 1'b1;
        step(10);
      end
    end
    mode = 2'b00;
  endtask

  task automatic test_ena();
    int seen;
    do_reset();
    ena  = 1'b0;
    seen = 0;
    s_n[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (changed !== 8'h00) seen++;
    end
    s_n[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (changed !== 8'h00) seen++;
    end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL ena_frozen_q: got %h expected %h", q, 8'h00); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL ena_frozen_changed: got %0d pulses expected 0", seen); end
    s_n[1] = 1'b0;
    step(10);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL ena_filtered_q: got %h expected %h", q, 8'h00); end
    ena = 1'b1;
    step(1);
    checks++; if (q !== 8'h02) begin errors++; $display("FAIL ena_reenable_q: got %h expected %h", q, 8'h02); end
    checks++; if (changed !== 8'h02) begin errors++; $display("FAIL ena_reenable_changed: got %h expected %h", changed, 8'h02); end
  endtask

  task automatic test_async_reset();
    do_reset();
    s_n[2] = 1'b0;
    step(7);
    checks++; if (q !== 8'h04) begin errors++; $display("FAIL arst_pre_q: got %h expected %h", q, 8'h04); end
    // Channel 6 starts filtering so the reset lands on a partial count.
    s_n[6] = 1'b0;
    step(3);
    rst_n = 1'b0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL arst_now_q: got %h expected %h", q, 8'h00); end
    checks++; if (qn !== 8'hFF) begin errors++; $display("FAIL arst_now_qn: got %h expected %h", qn, 8'hFF); end
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL arst_now_changed: got %h expected %h", changed, 8'h00); end
    rst_n = 1'b1;
    step(6);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL arst_early_q: got %h expected %h", q, 8'h00); end
    step(1);
    checks++; if (q !== 8'h44) begin errors++; $display("FAIL arst_edge7_q: got %h expected %h", q, 8'h44); end
    checks++; if (changed !== 8'h44) begin errors++; $display("FAIL arst_edge7_changed: got %h expected %h", changed, 8'h44); end
  endtask

  task automatic test_back_to_back();
    int bad_qn;
    do_reset();
    bad_qn = 0;
    s_n = 8'h00;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (qn !== ~q) bad_qn++;
    end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL all_set_early_q: got %h expected %h", q, 8'h00); end
    step(1);
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL all_set_q: got %h expected %h", q, 8'hFF); end
    checks++; if (changed !== 8'hFF) begin errors++; $display("FAIL all_set_changed: got %h expected %h", changed, 8'hFF); end
    step(1);
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL all_set_pulse_end: got %h expected %h", changed, 8'h00); end
    s_n = 8'hFF;
    r_n = 8'h00;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (qn !== ~q) bad_qn++;
    end
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL all_rst_early_q: got %h expected %h", q, 8'hFF); end
    step(1);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL all_rst_q: got %h expected %h", q, 8'h00); end
    checks++; if (changed !== 8'hFF) begin errors++; $display("FAIL all_rst_changed: got %h expected %h", changed, 8'hFF); end
    step(1);
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL all_rst_pulse_end: got %h expected %h", changed, 8'h00); end
    checks++; if (bad_qn !== 0) begin errors++; $display("FAIL qn_inverse: got %0d bad cycles expected 0", bad_qn); end
    r_n = 8'hFF;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_set_latency();
    test_glitch();
    test_conflict_modes();
    test_ena();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
